// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers and MTHI/MTLO writes.
// Optional build macro MULDIV_FAST_MULT_EN: single-cycle multiplier for MULT/MULTU.
module muldiv_unit (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Flush,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [2:0] OpMult  = 3'b000;
  localparam logic [2:0] OpMultu = 3'b001;
  localparam logic [2:0] OpDiv   = 3'b010;
  localparam logic [2:0] OpDivu  = 3'b011;
  localparam logic [2:0] OpMthi  = 3'b100;
  localparam logic [2:0] OpMtlo  = 3'b101;

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_t;

  state_t      state;
  logic [63:0] acc;      // mult: {partial sum, multiplier}; div: {remainder, quotient}
  logic [31:0] opa;      // multiplicand or divisor magnitude
  logic [5:0]  cnt;
  logic        is_div;
  logic        psign;
  logic        qsign;
  logic        rsign;
  logic        done_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  // Issue-side decode and operand conditioning
  logic        op_signed;
  logic        op_mul;
  logic        op_div;
  logic        op_iter;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [63:0] start_acc;
  logic [31:0] start_opa;

  always_comb begin
    op_signed = (Op == OpMult) || (Op == OpDiv);
    op_mul    = (Op == OpMult) || (Op == OpMultu);
    op_div    = (Op == OpDiv)  || (Op == OpDivu);
`ifdef MULDIV_FAST_MULT_EN
    op_iter   = op_div;
`else
    op_iter   = op_div || op_mul;
`endif
    a_neg     = op_signed & A[31];
    b_neg     = op_signed & B[31];
    a_mag     = a_neg ? (~A + 32'd1) : A;
    b_mag     = b_neg ? (~B + 32'd1) : B;
    if (op_div) begin
      start_acc = {32'd0, a_mag};
      start_opa = b_mag;
    end else begin
      start_acc = {32'd0, b_mag};
      start_opa = a_mag;
    end
  end

`ifdef MULDIV_FAST_MULT_EN
  logic [63:0] fast_a;
  logic [63:0] fast_b;
  logic [63:0] fast_prod;

  // Low 64 bits of a 64x64 product of extended operands are correct for both signednesses
  always_comb begin
    fast_a    = {{32{a_neg}}, A};
    fast_b    = {{32{b_neg}}, B};
    fast_prod = fast_a * fast_b;
  end
`endif

  // One iteration step for each algorithm
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_trial;
  logic [32:0] div_diff;
  logic        div_ge;
  logic [63:0] div_next;

  always_comb begin
    mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opa} : 33'd0);
    mul_next  = {mul_sum, acc[31:1]};
    div_trial = {acc[63:32], acc[31]};
    div_diff  = div_trial - {1'b0, opa};
    div_ge    = div_trial >= {1'b0, opa};
    if (div_ge) begin
      div_next = {div_diff[31:0], acc[30:0], 1'b1};
    end else begin
      div_next = {div_trial[31:0], acc[30:0], 1'b0};
    end
  end

  // Sign correction applied in the FIX state
  logic [63:0] prod;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] fix_hi;
  logic [31:0] fix_lo;

  always_comb begin
    prod   = psign ? (~acc + 64'd1) : acc;
    quo    = qsign ? (~acc[31:0] + 32'd1) : acc[31:0];
    rem    = rsign ? (~acc[63:32] + 32'd1) : acc[63:32];
    fix_hi = is_div ? rem : prod[63:32];
    fix_lo = is_div ? quo : prod[31:0];
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state  <= StIdle;
      acc    <= 64'd0;
      opa    <= 32'd0;
      cnt    <= 6'd0;
      is_div <= 1'b0;
      psign  <= 1'b0;
      qsign  <= 1'b0;
      rsign  <= 1'b0;
      done_q <= 1'b0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
    end else begin
      done_q <= 1'b0;
      if (Flush) begin
        state <= StIdle;
      end else begin
        case (state)
          StIdle: begin
            if (Start && op_iter) begin
              acc    <= start_acc;
              opa    <= start_opa;
              cnt    <= 6'd0;
              is_div <= op_div;
              psign  <= a_neg ^ b_neg;
              // Divide by zero keeps the all-ones quotient unsigned-looking
              qsign  <= (a_neg ^ b_neg) & (B != 32'd0);
              rsign  <= a_neg;
              state  <= StRun;
            end else if (Start) begin
              case (Op)
                OpMthi: hi_q <= A;
                OpMtlo: lo_q <= A;
`ifdef MULDIV_FAST_MULT_EN
                OpMult, OpMultu: begin
                  hi_q   <= fast_prod[63:32];
                  lo_q   <= fast_prod[31:0];
                  done_q <= 1'b1;
                end
`endif
                default: ;
              endcase
            end
          end
          StRun: begin
            acc <= is_div ? div_next : mul_next;
            cnt <= cnt + 6'd1;
            if (cnt == 6'd31) begin
              state <= StFix;
            end
          end
          StFix: begin
            hi_q   <= fix_hi;
            lo_q   <= fix_lo;
            done_q <= 1'b1;
            state  <= StIdle;
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

  assign Busy = (state != StIdle);
  assign Done = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed vectors push expected HI/LO, a monitor checks on Done.
module tb_muldiv_unit;

  logic        clock;
  logic        reset_n;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        Flush;
  logic        Busy;
  logic        Done;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] sb[$];

`ifdef MULDIV_FAST_MULT_EN
  localparam int MulBusy = 0;
`else
  localparam int MulBusy = 33;
`endif

  muldiv_unit dut (
    .clock  (clock),
    .reset_n(reset_n),
    .Start  (Start),
    .Op     (Op),
    .A      (A),
    .B      (B),
    .Flush  (Flush),
    .Busy   (Busy),
    .Done   (Done),
    .HI     (HI),
    .LO     (LO)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every Done pulse consumes one expected result
  always @(negedge clock) begin
    if (reset_n && Done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        check("hi", {32'd0, HI}, {32'd0, e[63:32]});
        check("lo", {32'd0, LO}, {32'd0, e[31:0]});
        check("busy_with_done", {63'd0, Busy}, 64'd0);
      end
    end
  end

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input int ebusy);
    int n;
    @(negedge clock);
    Start = 1'b1; Op = op; A = a; B = b;
    sb.push_back({ehi, elo});
    @(negedge clock);
    Start = 1'b0;
    n = 0;
    while (Busy && n < 100) begin
      n++;
      @(negedge clock);
    end
    check("busy_cycles", 64'(n), 64'(ebusy));
  endtask

  task automatic start_only(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    Start = 1'b1; Op = op; A = a; B = b;
    @(negedge clock);
    Start = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; Start = 1'b0; Op = 3'd0; A = 32'd0; B = 32'd0; Flush = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_hi", {32'd0, HI}, 64'd0);
    check("rst_lo", {32'd0, LO}, 64'd0);
    check("rst_busy", {63'd0, Busy}, 64'd0);
    check("rst_done", {63'd0, Done}, 64'd0);
    reset_n = 1'b1;

    run_op(3'b000, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, MulBusy);
    run_op(3'b001, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, MulBusy);
    run_op(3'b000, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, MulBusy);
    run_op(3'b010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
    run_op(3'b010, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 33);
    run_op(3'b010, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF, 33);
    run_op(3'b011, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF, 33);
    run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33);
    run_op(3'b011, 32'd100, 32'd7, 32'd2, 32'd14, 33);

    // MTHI then MTLO on consecutive edges
    @(negedge clock);
    Start = 1'b1; Op = 3'b100; A = 32'hDEAD_BEEF;
    @(negedge clock);
    check("mthi_hi", {32'd0, HI}, {32'd0, 32'hDEAD_BEEF});
    check("mthi_busy", {63'd0, Busy}, 64'd0);
    Op = 3'b101; A = 32'h0BAD_F00D;
    @(negedge clock);
    Start = 1'b0;
    check("mtlo_lo", {32'd0, LO}, {32'd0, 32'h0BAD_F00D});
    check("mtlo_hi", {32'd0, HI}, {32'd0, 32'hDEAD_BEEF});
    check("mtlo_busy", {63'd0, Busy}, 64'd0);

    // Reserved opcode does nothing
    start_only(3'b110, 32'h5555_5555, 32'd1);
    check("rsvd_busy", {63'd0, Busy}, 64'd0);
    check("rsvd_hi", {32'd0, HI}, {32'd0, 32'hDEAD_BEEF});
    check("rsvd_lo", {32'd0, LO}, {32'd0, 32'h0BAD_F00D});

    // Flush together with MTHI drops the write
    @(negedge clock);
    Start = 1'b1; Op = 3'b100; A = 32'h1111_1111; Flush = 1'b1;
    @(negedge clock);
    Start = 1'b0; Flush = 1'b0;
    check("flush_mthi_hi", {32'd0, HI}, {32'd0, 32'hDEAD_BEEF});

    // Start while busy is ignored
    start_only(3'b011, 32'd100, 32'd7);
    sb.push_back({32'd2, 32'd14});
    repeat (4) @(negedge clock);
    Start = 1'b1; Op = 3'b100; A = 32'hFFFF_0000;
    @(negedge clock);
    Start = 1'b0;
    begin
      int n;
      n = 0;
      while (Busy && n < 100) begin
        n++;
        @(negedge clock);
      end
      check("busy_start_ignored_done", {63'd0, Done}, 64'd1);
    end
    @(negedge clock);
    check("busy_start_hi", {32'd0, HI}, 64'd2);

    // Flush mid-divide: no Done, HI/LO unchanged
    start_only(3'b011, 32'd1000, 32'd3);
    repeat (8) @(negedge clock);
    Flush = 1'b1;
    @(negedge clock);
    Flush = 1'b0;
    check("flush_busy", {63'd0, Busy}, 64'd0);
    repeat (40) @(negedge clock);
    check("flush_hi", {32'd0, HI}, 64'd2);
    check("flush_lo", {32'd0, LO}, 64'd14);

    // Reset mid-divide clears HI/LO
    start_only(3'b011, 32'd1000, 32'd3);
    repeat (18) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    check("rst_mid_hi", {32'd0, HI}, 64'd0);
    check("rst_mid_lo", {32'd0, LO}, 64'd0);
    check("rst_mid_busy", {63'd0, Busy}, 64'd0);
    repeat (40) @(negedge clock);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
